// File: rtl/ram_uart_ctrl_p.sv
// Shared SRAM/UART bus controller: serialises CPU requests, buffers UART RX bytes in a FIFO, exposes a status word.
// Optional build macro RX_OVERWRITE_EN: a full FIFO drops its oldest entry to accept a new RX byte.
module ram_uart_ctrl_p #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 18,
  parameter int                FIFO_AW   = 4,
  parameter logic [ADDR_W-1:0] UART_ADDR = 18'h0BF00,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 18'h0BF01,
  parameter int                RAM_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  input  logic              data_ready,
  output logic              rdn,
  input  logic              tbre,
  input  logic              tsre,
  output logic              wrn,
  output logic [FIFO_AW:0]  fifo_count,
  output logic              rx_overflow
);
  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [2:0]         WAIT_C  = 3'(RAM_WAIT);

  typedef enum logic [3:0] {
    IDLE, RX_STB, RX_CAP, RX_FIN, POP, STAT, TX_WAIT, TX_STB,
    ACC_SETUP, ACC_ACT, ACC_FIN, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                wr_q, wr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [FIFO_AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                en_n_q, en_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                rdn_q, rdn_d, wrn_q, wrn_d, drv_q, drv_d;
  logic                full, rx_ok, ovf_set, ovf_clr, fifo_we;
  logic [DATA_W-1:0]   fifo_mem [DEPTH];

  assign full = (count_q == DEPTH_C);

`ifdef RX_OVERWRITE_EN
  assign rx_ok = data_ready;
`else
  assign rx_ok = data_ready && !full;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_set = 1'b0;
    ovf_clr = 1'b0;
    fifo_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_ok) begin
          state_d = RX_STB;
        end else begin
          // Byte left waiting in the UART: flag it, but still serve the CPU.
          if (data_ready && full) ovf_set = 1'b1;
          if (req) begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            wr_d    = mem_wr;
            if (mem_addr == UART_ADDR)                state_d = mem_wr ? TX_WAIT : POP;
            else if (mem_addr == STAT_ADDR && mem_rd) state_d = STAT;
            else                                      state_d = ACC_SETUP;
          end
        end
      end
      RX_STB: state_d = RX_CAP;
      RX_CAP: begin
        fifo_we = 1'b1;
        tail_d  = tail_q + FIFO_AW'(1);
        if (full) begin
          head_d  = head_q + FIFO_AW'(1);
          ovf_set = 1'b1;
        end else begin
          count_d = count_q + (FIFO_AW+1)'(1);
        end
        state_d = RX_FIN;
      end
      RX_FIN: state_d = IDLE;
      POP: begin
        if (count_q != '0) begin
          rdata_d = fifo_mem[head_q];
          head_d  = head_q + FIFO_AW'(1);
          count_d = count_q - (FIFO_AW+1)'(1);
        end else begin
          rdata_d = '0;
        end
        state_d = DONE;
      end
      STAT: begin
        rdata_d = {{(DATA_W-4){1'b0}}, ovf_q, full, (count_q != '0), (tbre & tsre)};
        ovf_clr = 1'b1;
        state_d = DONE;
      end
      TX_WAIT: if (tbre && tsre) begin
        state_d = TX_STB;
        cnt_d   = '0;
      end
      TX_STB: begin
        if (cnt_q == 3'd1) state_d = DONE;
        else               cnt_d   = cnt_q + 3'd1;
      end
      ACC_SETUP: begin
        state_d = ACC_ACT;
        cnt_d   = '0;
      end
      ACC_ACT: begin
        if (cnt_q == WAIT_C) begin
          state_d = ACC_FIN;
          if (!wr_q) rdata_d = ram_data;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ACC_FIN: state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    en_n_d = !(state_d inside {ACC_SETUP, ACC_ACT});
    oe_n_d = !(state_d == ACC_ACT && !wr_d);
    we_n_d = !(state_d == ACC_ACT && wr_d);
    rdn_d  = !(state_d inside {RX_STB, RX_CAP});
    wrn_d  = !(state_d == TX_STB);
    drv_d  = (wr_d && (state_d inside {ACC_SETUP, ACC_ACT, ACC_FIN})) || (state_d == TX_STB);
    done_d = state_d inside {ACC_FIN, DONE};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      en_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      en_n_q  <= en_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      drv_q   <= drv_d;
    end
  end

  // UART drives only the low byte; upper bits are forced to zero on capture.
  always_ff @(posedge clk) begin
    if (fifo_we) fifo_mem[tail_q] <= {{(DATA_W-8){1'b0}}, ram_data[7:0]};
  end

  assign ram_data    = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign ram_addr    = addr_q;
  assign ram_en_n    = en_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign rdn         = rdn_q;
  assign wrn         = wrn_q;
  assign fifo_count  = count_q;
  assign rx_overflow = ovf_q;
endmodule

// File: doc/ram_uart_ctrl_p.md
Name: ram_uart_ctrl_p

Overview:
Parametrised successor of the single-port RAM1/UART controller. It serialises CPU memory requests onto one shared async SRAM/UART data bus. It buffers received UART bytes in a configurable-depth RX FIFO and exposes a memory-mapped status word. The RAM access length is configurable through wait states. The block sits between the MEM pipeline stage and the board's RAM1/UART pins.

Parameters:
DATA_W, 16, width of the data bus, the FIFO entries and rdata
ADDR_W, 18, RAM address width
FIFO_AW, 4, log2 of RX FIFO depth (depth 16)
UART_ADDR, 18'h0BF00, data register; a read pops the FIFO, a write transmits
STAT_ADDR, 18'h0BF01, read-only status register
RAM_WAIT, 1, extra cycles the OE/WE strobe is held low (0..7)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req  in  1  request valid; level, held until done
mem_rd  in  1  read request
mem_wr  in  1  write request (mem_rd and mem_wr never both 1)
mem_addr  in  ADDR_W  request address
mem_wdata  in  DATA_W  write data
done  out  1  one-cycle completion pulse
rdata  out  DATA_W  read result, valid with done and held until the next read done
ram_addr  out  ADDR_W  SRAM address (registered)
ram_data  inout  DATA_W  shared SRAM/UART data bus
ram_en_n, ram_oe_n, ram_we_n  out  1 each  SRAM controls, active low
data_ready  in  1  UART RX byte available
rdn  out  1  UART read strobe, active low
tbre, tsre  in  1 each  UART transmitter buffer empty / shift register empty
wrn  out  1  UART write strobe, active low
fifo_count  out  FIFO_AW+1  current RX FIFO occupancy
rx_overflow  out  1  sticky overflow flag; cleared by reading STAT_ADDR

Behaviour:
- Reset (async, rst=0): state IDLE; all strobes (ram_*_n, rdn, wrn) = 1; done=0; rdata=0; ram_addr=0; FIFO pointers and count = 0; rx_overflow=0; ram_data = Z.
- ram_data is driven with the latched write data only in ACC_* states of a RAM write and in TX_STB. It is Z at all other times.
- IDLE arbitration is evaluated every cycle:
  - data_ready=1 with FIFO not full -> RX_STB. RX has priority over req.
  - Otherwise, req=1 -> latch mem_addr, mem_wdata and op, then decode:
    - UART_ADDR + write -> TX_WAIT
    - UART_ADDR + read -> POP
    - STAT_ADDR + read -> STAT
    - any other address -> ACC_SETUP
- RX path:
  - RX_STB: rdn=0.
  - RX_CAP: rdn=0; capture ram_data[7:0] zero-extended into the FIFO tail.
  - Next cycle: rdn=1, tail+1 mod depth, count+1, return to IDLE.
  - RX takes 3 cycles and never asserts done.
- POP (1 cycle):
  - FIFO not empty -> rdata=head entry, head+1, count-1.
  - FIFO empty -> rdata=0, pointers unchanged.
  - done pulses the following cycle.
- STAT: rdata = {DATA_W-4 zeros, rx_overflow, count==depth, count!=0, tbre&tsre}. Clears rx_overflow; an overflow in the same cycle wins. done pulses the following cycle.
- TX_WAIT: hold until tbre&tsre=1. Then TX_STB: wrn=0 for 2 cycles with data driven. Then wrn=1 and done.
- RAM path:
  - ACC_SETUP: ram_en_n=0; ram_addr valid.
  - ACC_ACT: ram_oe_n=0 (read) or ram_we_n=0 (write) for 1+RAM_WAIT cycles, counted by a 3-bit counter.
  - ACC_FIN: strobes high; a read captures rdata from ram_data; done pulses.
  - Total latency from req acceptance to done = 3+RAM_WAIT cycles.
- done pulses exactly once per request. The requester must drop or change req the cycle after done. A req still high in IDLE is a new request.
- Overflow: data_ready=1 with FIFO full -> no rdn strobe; rx_overflow=1; the byte stays in the UART. This is the default behaviour; see the optional feature.
- Simultaneous RX capture and POP cannot occur, because the FSM serialises them. fifo_count never exceeds 2^FIFO_AW.
- Reset mid-operation releases all strobes immediately and discards the FIFO. No done is generated for the aborted request.

Optional Feature:
RX_OVERWRITE_EN:
- Defined: when the FIFO is full and data_ready=1, the controller performs RX_STB/RX_CAP anyway. It overwrites the oldest entry, advances both head and tail, leaves count at depth, and sets rx_overflow.
- Undefined: the default no-strobe and overflow-flag behaviour above applies.

Test Plan:
1. RAM_WAIT=1: write 16'hA5A5 to 0x00010, then read 0x00010 -> ram_we_n low 2 cycles, done 4 cycles after acceptance, rdata=16'hA5A5.
2. Three RX bytes 0x31, 0x32, 0x33 via data_ready -> fifo_count=3. Three reads of UART_ADDR -> rdata 0x0031, 0x0032, 0x0033, then fifo_count=0.
3. Read UART_ADDR with the FIFO empty -> rdata=0, done, fifo_count stays 0.
4. Write 16'h0041 to UART_ADDR with tbre=0 for 5 cycles -> wrn stays 1 until tbre&tsre=1, then 2 cycles low, then done.
5. Feed 17 bytes at FIFO_AW=4 -> fifo_count=16; STAT read returns 16'h000E when tbre=0, or 16'h000F when tbre=tsre=1. rx_overflow is 0 after the read. With RX_OVERWRITE_EN, the first pop returns byte 2.
6. data_ready and req asserted in the same IDLE cycle -> RX serviced first, the RAM request completes afterwards. Assert rst mid-ACC_ACT -> all strobes 1 asynchronously and no done.
